// File: rtl/basic_dp_pkg.sv
// ---------------------------------------------------------------------------
// basic_dp_pkg
//   Shared definitions for the basic_datapath_p accumulator datapath:
//     - ALU operation codes driven on alu_op
//     - bus source select codes driven on sel_bus
//     - bit positions inside the ld_vec / inc_vec / clr_vec control vectors
//     - memory read FSM state encoding and its latency counter width
// ---------------------------------------------------------------------------
package basic_dp_pkg;

    // ALU operation codes (alu_op). Codes 11..15 pass AC and keep E.
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LDA = 4'd2;
    localparam logic [3:0] OP_CMA = 4'd3;
    localparam logic [3:0] OP_CIR = 4'd4;
    localparam logic [3:0] OP_CIL = 4'd5;
    localparam logic [3:0] OP_INC = 4'd6;
    localparam logic [3:0] OP_CLA = 4'd7;
    localparam logic [3:0] OP_SUB = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_XOR = 4'd10;

    // Bus source select codes (sel_bus)
    localparam logic [2:0] BUS_ZERO = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_HOLD = 3'd7;

    // Bit positions in the control vectors, order {TR,IR,AC,DR,PC,AR}
    localparam int IDX_AR = 0;
    localparam int IDX_PC = 1;
    localparam int IDX_DR = 2;
    localparam int IDX_AC = 3;
    localparam int IDX_IR = 4;
    localparam int IDX_TR = 5;

    // Read latency counter only has to hold RD_LAT-1, and RD_LAT tops out at 4
    localparam int CNT_W = 2;

    // Memory read FSM
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/basic_datapath_p_alu.sv
// ---------------------------------------------------------------------------
// dp_alu
//   Purely combinational ALU for the accumulator datapath.  The AC is always
//   the primary operand, DR the secondary one, and E both feeds the rotates
//   and is the default carry so that ops which do not produce a carry leave
//   E unchanged when the control unit loads E from the ALU.
//
//   Ports:
//     ac     [DW-1:0]  accumulator operand
//     dr     [DW-1:0]  data register operand
//     e      1         current E flag
//     op     [3:0]     operation code (see basic_dp_pkg OP_*)
//     result [DW-1:0]  operation result
//     carry  1         value E takes when loaded from the ALU
//     z      1         result is zero
//     n      1         result sign bit
//     ovf    1         signed overflow for ADD, SUB and INC, otherwise 0
// ---------------------------------------------------------------------------
module dp_alu
    import basic_dp_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] ac,
    input  logic [DW-1:0] dr,
    input  logic          e,
    input  logic [3:0]    op,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          z,
    output logic          n,
    output logic          ovf
);

    logic [DW:0] sum_add;
    logic [DW:0] sum_sub;
    logic [DW:0] sum_inc;

    // Carry-out of AC + ~DR + 1 is 1 exactly when no borrow occurs
    assign sum_add = {1'b0, ac} + {1'b0, dr};
    assign sum_sub = {1'b0, ac} + {1'b0, ~dr} + {{DW{1'b0}}, 1'b1};
    assign sum_inc = {1'b0, ac} + {{DW{1'b0}}, 1'b1};

    // Overflow: ADD when operands agree in sign and the result does not,
    // SUB when operands differ in sign and the result left AC's sign,
    // INC only when a positive AC wraps to negative.
    always_comb begin
        result = ac;
        carry  = e;
        ovf    = 1'b0;
        case (op)
            OP_AND: result = ac & dr;
            OP_ADD: begin
                result = sum_add[DW-1:0];
                carry  = sum_add[DW];
                ovf    = (ac[DW-1] == dr[DW-1]) && (sum_add[DW-1] != ac[DW-1]);
            end
            OP_LDA: result = dr;
            OP_CMA: result = ~ac;
            OP_CIR: begin
                result = {e, ac[DW-1:1]};
                carry  = ac[0];
            end
            OP_CIL: begin
                result = {ac[DW-2:0], e};
                carry  = ac[DW-1];
            end
            OP_INC: begin
                result = sum_inc[DW-1:0];
                carry  = sum_inc[DW];
                ovf    = ~ac[DW-1] & sum_inc[DW-1];
            end
            OP_CLA: result = '0;
            OP_SUB: begin
                result = sum_sub[DW-1:0];
                carry  = sum_sub[DW];
                ovf    = (ac[DW-1] != dr[DW-1]) && (sum_sub[DW-1] != ac[DW-1]);
            end
            OP_OR:  result = ac | dr;
            OP_XOR: result = ac ^ dr;
            default: begin
                result = ac;
                carry  = e;
            end
        endcase
    end

    assign z = (result == '0);
    assign n = result[DW-1];

endmodule

// File: rtl/basic_datapath_p.sv
// ---------------------------------------------------------------------------
// basic_datapath_p
//   Accumulator datapath with AR, PC, DR, AC, IR, TR, an E flag, a common
//   bus, the dp_alu and an on-block memory of 2**AW words.  An external
//   control unit drives it cycle by cycle.  Memory writes complete in the
//   request cycle; reads complete RD_LAT cycles later behind mem_busy and
//   are announced by a one-cycle rd_valid pulse, after which the word sits
//   in the read-hold register (bus source 7) until the next read completes.
//   Requests made while busy, or a read issued together with a write, are
//   ignored and set the sticky mem_err flag.
//
//   Parameters:
//     DW      data width of DR, AC, IR, TR, bus and memory (DW >= AW)
//     AW      address width of AR and PC
//     RD_LAT  memory read latency in cycles, 1..4
//
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     sel_bus [2:0]                 bus source select
//     ld_vec/inc_vec/clr_vec [5:0]  per-register load/increment/clear,
//                                   bit order {TR,IR,AC,DR,PC,AR}
//     alu_op [3:0]                  ALU operation
//     e_ld, e_clr, e_cmp            E load from carry / clear / complement
//     mem_rd, mem_wr                memory read start / write
//     out_AR, out_PC [AW-1:0]       address register contents
//     out_DR, out_AC, out_IR,
//     out_TR [DW-1:0]               data register contents
//     e_flag                        E register
//     z_alu, n_alu, ovf_alu         combinational ALU flags
//     mem_busy                      read in progress
//     rd_valid                      read data just captured (one cycle)
//     mem_err                       sticky: a request was ignored
// ---------------------------------------------------------------------------
module basic_datapath_p
    import basic_dp_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 12,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    sel_bus,
    input  logic [5:0]    ld_vec,
    input  logic [5:0]    inc_vec,
    input  logic [5:0]    clr_vec,
    input  logic [3:0]    alu_op,
    input  logic          e_ld,
    input  logic          e_clr,
    input  logic          e_cmp,
    input  logic          mem_rd,
    input  logic          mem_wr,
    output logic [AW-1:0] out_AR,
    output logic [AW-1:0] out_PC,
    output logic [DW-1:0] out_DR,
    output logic [DW-1:0] out_AC,
    output logic [DW-1:0] out_IR,
    output logic [DW-1:0] out_TR,
    output logic          e_flag,
    output logic          z_alu,
    output logic          n_alu,
    output logic          ovf_alu,
    output logic          mem_busy,
    output logic          rd_valid,
    output logic          mem_err
);

    localparam int DEPTH = 1 << AW;

    // Architectural registers
    logic [AW-1:0] ar_q, ar_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] dr_q, dr_d;
    logic [DW-1:0] ac_q, ac_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] tr_q, tr_d;
    logic          e_q,  e_d;

    // Memory side state
    mem_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    rd_addr_q;
    logic [DW-1:0]    hold_q;
    logic             rd_valid_q;
    logic             mem_err_q;
    logic [DW-1:0]    mem [DEPTH];
    logic             mem_we;

    logic [DW-1:0] bus_data;
    logic [DW-1:0] alu_result;
    logic          alu_carry;

    // Generic register update with priority clear > load > increment.
    // Increment wraps naturally at the register width.
    function automatic logic [DW-1:0] next_dw(
        input logic [DW-1:0] cur,
        input logic [DW-1:0] load_val,
        input logic          clr,
        input logic          ld,
        input logic          inc
    );
        if (clr)      return '0;
        else if (ld)  return load_val;
        else if (inc) return cur + DW'(1);
        else          return cur;
    endfunction

    function automatic logic [AW-1:0] next_aw(
        input logic [AW-1:0] cur,
        input logic [AW-1:0] load_val,
        input logic          clr,
        input logic          ld,
        input logic          inc
    );
        if (clr)      return '0;
        else if (ld)  return load_val;
        else if (inc) return cur + AW'(1);
        else          return cur;
    endfunction

    // Common bus source mux; address registers are zero-extended
    always_comb begin
        bus_data = '0;
        case (sel_bus)
            BUS_ZERO: bus_data = '0;
            BUS_AR:   bus_data = DW'(ar_q);
            BUS_PC:   bus_data = DW'(pc_q);
            BUS_DR:   bus_data = dr_q;
            BUS_AC:   bus_data = ac_q;
            BUS_IR:   bus_data = ir_q;
            BUS_TR:   bus_data = tr_q;
            BUS_HOLD: bus_data = hold_q;
        endcase
    end

    dp_alu #(
        .DW(DW)
    ) u_alu (
        .ac     (ac_q),
        .dr     (dr_q),
        .e      (e_q),
        .op     (alu_op),
        .result (alu_result),
        .carry  (alu_carry),
        .z      (z_alu),
        .n      (n_alu),
        .ovf    (ovf_alu)
    );

    // Next-state for all registers; AC is the only one fed by the ALU,
    // AR and PC take the low AW bits of the bus
    always_comb begin
        ar_d = next_aw(ar_q, bus_data[AW-1:0], clr_vec[IDX_AR], ld_vec[IDX_AR], inc_vec[IDX_AR]);
        pc_d = next_aw(pc_q, bus_data[AW-1:0], clr_vec[IDX_PC], ld_vec[IDX_PC], inc_vec[IDX_PC]);
        dr_d = next_dw(dr_q, bus_data,   clr_vec[IDX_DR], ld_vec[IDX_DR], inc_vec[IDX_DR]);
        ac_d = next_dw(ac_q, alu_result, clr_vec[IDX_AC], ld_vec[IDX_AC], inc_vec[IDX_AC]);
        ir_d = next_dw(ir_q, bus_data,   clr_vec[IDX_IR], ld_vec[IDX_IR], inc_vec[IDX_IR]);
        tr_d = next_dw(tr_q, bus_data,   clr_vec[IDX_TR], ld_vec[IDX_TR], inc_vec[IDX_TR]);

        // E priority: clear > complement > load from ALU carry
        e_d = e_q;
        if (e_clr)      e_d = 1'b0;
        else if (e_cmp) e_d = ~e_q;
        else if (e_ld)  e_d = alu_carry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_q <= '0;
            pc_q <= '0;
            dr_q <= '0;
            ac_q <= '0;
            ir_q <= '0;
            tr_q <= '0;
            e_q  <= 1'b0;
        end else begin
            ar_q <= ar_d;
            pc_q <= pc_d;
            dr_q <= dr_d;
            ac_q <= ac_d;
            ir_q <= ir_d;
            tr_q <= tr_d;
            e_q  <= e_d;
        end
    end

    // Memory read FSM.  The read address is latched on acceptance so the
    // control unit may reuse AR while the read is outstanding.  The counter
    // starts at RD_LAT-1 and the word is captured when it reaches zero,
    // giving RD_LAT busy cycles followed by the rd_valid cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            hold_q     <= '0;
            rd_valid_q <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_rd && mem_wr) begin
                        mem_err_q <= 1'b1;
                    end else if (mem_rd) begin
                        rd_addr_q <= ar_q;
                        cnt_q     <= CNT_W'(RD_LAT - 1);
                        state_q   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rd || mem_wr) begin
                        mem_err_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        hold_q     <= mem[rd_addr_q];
                        rd_valid_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Writes are only honoured while idle; a write paired with a read still
    // lands, only the read is dropped.  Memory contents survive reset.
    assign mem_we = mem_wr && (state_q == ST_IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ar_q] <= bus_data;
        end
    end

    assign out_AR   = ar_q;
    assign out_PC   = pc_q;
    assign out_DR   = dr_q;
    assign out_AC   = ac_q;
    assign out_IR   = ir_q;
    assign out_TR   = tr_q;
    assign e_flag   = e_q;
    assign mem_busy = (state_q == ST_RD_WAIT);
    assign rd_valid = rd_valid_q;
    assign mem_err  = mem_err_q;

endmodule

// File: doc/basic_datapath_p.md
Name: basic_datapath_p

Overview:
- Parametrised next-generation accumulator datapath: AR, PC, DR, AC, IR, TR plus E flag, a common bus, an ALU with an extended op set, and on-block memory.
- Memory reads take a configurable number of cycles behind a busy/valid handshake.
- Driven cycle-by-cycle by the external control unit, which must honour mem_busy.

Parameters:
- DW, 16, data width of DR, AC, IR, TR, the bus and memory words.
- AW, 12, address width of AR and PC; memory depth is 2**AW words.
- RD_LAT, 1, memory read latency in cycles, legal range 1..4.

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sel_bus  input  3  bus source select.
- ld_vec  input  6  load enables, bit order {TR,IR,AC,DR,PC,AR}.
- inc_vec  input  6  increment enables, same bit order.
- clr_vec  input  6  clear enables, same bit order.
- alu_op  input  4  ALU operation.
- e_ld, e_clr, e_cmp  input  1 each  E flag load from ALU carry / clear / complement.
- mem_rd, mem_wr  input  1 each  memory read start / memory write.
- out_AR, out_PC  output  AW  register contents.
- out_DR, out_AC, out_IR, out_TR  output  DW  register contents.
- e_flag, z_alu, n_alu, ovf_alu  output  1 each  E register and combinational ALU flags.
- mem_busy  output  1  read in progress.
- rd_valid  output  1  one-cycle pulse when read data has been captured.
- mem_err  output  1  sticky flag: a request was ignored.

Behaviour:
- Reset: all registers, E, read-hold register, rd_valid and mem_err go to 0; FSM goes to IDLE.
- Reset mid-read aborts the read; no rd_valid pulse. Memory contents are not reset.
- Bus select codes: 0 = zero, 1 = AR, 2 = PC, 3 = DR, 4 = AC, 5 = IR, 6 = TR, 7 = read-hold register.
- AW-wide sources are zero-extended onto the bus; AR and PC take bus bits [AW-1:0].
- Per-register priority is clr > ld > inc. Increment wraps modulo 2**width.
- AR, PC, DR, IR and TR load from the bus. AC loads from the ALU result.
- ALU ops (combinational; carry into E):
  - 0 AND, 1 ADD, 2 LDA (pass DR), 3 CMA.
  - 4 CIR: {E, AC[DW-1:1]}, carry = AC[0].
  - 5 CIL: {AC[DW-2:0], E}, carry = AC[DW-1].
  - 6 INC (AC+1), 7 CLA (zero), 8 SUB (AC-DR; carry = no-borrow), 9 OR, 10 XOR.
  - 11..15 pass AC, carry = E.
- Flags: z_alu = (result == 0); n_alu = result[DW-1]; ovf_alu is two's-complement overflow for ADD, SUB and INC, else 0.
- E priority is e_clr > e_cmp > e_ld.
- Memory FSM states: IDLE, RD_WAIT.
  - IDLE + mem_wr: bus_data is written to mem[AR] at this edge; FSM stays in IDLE; mem_busy stays low.
  - IDLE + mem_rd (no mem_wr): AR is latched, counter loads RD_LAT-1, FSM goes to RD_WAIT; mem_busy is high from the next cycle.
  - RD_WAIT: counter decrements each cycle. At counter == 0, mem[latched AR] is captured into the read-hold register, rd_valid is high in the following cycle, and the FSM returns to IDLE.
  - Total latency: mem_rd cycle to rd_valid = RD_LAT+1 cycles.
  - AR changes during RD_WAIT do not affect the read.
- Ignored requests, each setting mem_err:
  - mem_rd or mem_wr while busy.
  - mem_rd together with mem_wr in IDLE: the write proceeds, the read is dropped.
- mem_err clears only on reset.
- Bus select 7 returns the last captured word until the next capture.

Decomposition:
- Package basic_dp_pkg holds the ALU op codes, bus select codes, ld/inc/clr bit indices and the FSM state encoding.
- The natural sub-module is dp_alu (parameter DW; inputs AC, DR, E, op; outputs result, carry, z, n, ovf).
- Registers are inline generic enable/clear/increment flops.

Test Plan:
- Reset then sel_bus=2, ld AR -> out_AR=0, out_PC=0, mem_busy=0, mem_err=0.
- AC=0x7FFF, DR=0x0001, op ADD, ld AC, e_ld -> AC=0x8000, ovf_alu=1, n_alu=1, E=0.
- AC=0x0001, E=1, op CIR, ld AC, e_ld -> AC=0x8000, E=1. Then CIL -> AC=0x0001, E=1.
- RD_LAT=3: mem[0x005]=0xBEEF, AR=0x005, pulse mem_rd -> mem_busy high 3 cycles, rd_valid at cycle 4, sel_bus=7 yields 0xBEEF.
- mem_rd while busy, and mem_rd with mem_wr -> first read completes unaffected, write lands, mem_err=1 and stays 1 until reset.
- Assert reset during RD_WAIT -> no rd_valid, FSM in IDLE, registers 0. PC=0xFFF with inc -> wraps to 0x000.
